// File: rtl/apb4_gpio_v2_if.sv
// APB4 bus bundle for the GPIO block: requester drives select/enable/address/data,
// the GPIO slave returns read data, ready and error.
interface apb4_gpio_v2_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_gpio_v2.sv
// APB4 GPIO controller: direction/output registers with set/clear/toggle aliases,
// synchronised and optionally debounced inputs, and per-pin level/edge interrupts
// collected into a sticky W1C status register.
module apb4_gpio_v2 #(
  parameter int PIN_NUM    = 32,
  parameter int SYNC_STAGE = 2,
  parameter int DB_WIDTH   = 8
) (
  input  logic               pclk,
  input  logic               presetn,
  apb4_gpio_v2_if.slave      apb,
  input  logic [PIN_NUM-1:0] gpio_in_i,
  output logic [PIN_NUM-1:0] gpio_out_o,
  output logic [PIN_NUM-1:0] gpio_dir_o,
  output logic               irq_o
);

  localparam logic [3:0] OFF_DIR     = 4'd0;
  localparam logic [3:0] OFF_IN      = 4'd1;
  localparam logic [3:0] OFF_OUT     = 4'd2;
  localparam logic [3:0] OFF_OUTSET  = 4'd3;
  localparam logic [3:0] OFF_OUTCLR  = 4'd4;
  localparam logic [3:0] OFF_OUTTGL  = 4'd5;
  localparam logic [3:0] OFF_INTEN   = 4'd6;
  localparam logic [3:0] OFF_INTTYPE = 4'd7;
  localparam logic [3:0] OFF_INTPOL  = 4'd8;
  localparam logic [3:0] OFF_INTBOTH = 4'd9;
  localparam logic [3:0] OFF_INTSTAT = 4'd10;
  localparam logic [3:0] OFF_DBTHR   = 4'd11;
  localparam logic [3:0] OFF_DBEN    = 4'd12;

  logic [3:0]         off;
  logic [PIN_NUM-1:0] wdata;
  logic               access;
  logic               err;
  logic               wr_en;
  logic               rd_en;

  logic [PIN_NUM-1:0] dir_q, out_q, inten_q, inttype_q, intpol_q, intboth_q;
  logic [PIN_NUM-1:0] intstat_q, dben_q;
  logic [DB_WIDTH-1:0] dbthr_q;
  logic               irq_q;

  logic [PIN_NUM-1:0] sync_q [SYNC_STAGE];
  logic [PIN_NUM-1:0] s;
  logic [PIN_NUM-1:0] db_q;
  logic [DB_WIDTH-1:0] cnt_q [PIN_NUM];
  logic [PIN_NUM-1:0] bypass;
  logic [PIN_NUM-1:0] d;
  logic [PIN_NUM-1:0] d_prev_q;

  logic [PIN_NUM-1:0] rise, fall, lvl_trig, edge_trig, trig;
  logic [PIN_NUM-1:0] set, w1c, inten_nxt, intstat_nxt;
  logic [PIN_NUM-1:0] rd_pins;
  logic [31:0]        rdata;
  logic [DB_WIDTH-1:0] dbthr_m1;
  logic               unused_bits;

  assign off    = apb.paddr[5:2];
  assign wdata  = apb.pwdata[PIN_NUM-1:0];
  assign access = apb.psel & apb.penable;
  // Offsets 13..15 and writes to the read-only IN register are rejected outright
  assign err    = access & ((off >= 4'd13) | (apb.pwrite & (off == OFF_IN)));
  assign wr_en  = access & apb.pwrite & ~err;
  assign rd_en  = access & ~apb.pwrite & ~err;

  assign apb.pready  = 1'b1;
  assign apb.pslverr = err;
  assign unused_bits = ^{apb.paddr[31:6], apb.paddr[1:0], apb.pwdata};

  // Configuration and output registers, written only by error-free accesses
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      dir_q     <= '0;
      out_q     <= '0;
      inttype_q <= '0;
      intpol_q  <= '0;
      intboth_q <= '0;
      dbthr_q   <= '0;
      dben_q    <= '0;
    end else if (wr_en) begin
      case (off)
        OFF_DIR:     dir_q     <= wdata;
        OFF_OUT:     out_q     <= wdata;
        OFF_OUTSET:  out_q     <= out_q | wdata;
        OFF_OUTCLR:  out_q     <= out_q & ~wdata;
        OFF_OUTTGL:  out_q     <= out_q ^ wdata;
        OFF_INTTYPE: inttype_q <= wdata;
        OFF_INTPOL:  intpol_q  <= wdata;
        OFF_INTBOTH: intboth_q <= wdata;
        OFF_DBTHR:   dbthr_q   <= apb.pwdata[DB_WIDTH-1:0];
        OFF_DBEN:    dben_q    <= wdata;
        default: ;
      endcase
    end
  end

  assign gpio_out_o = out_q;
  assign gpio_dir_o = dir_q;

  // Input synchroniser chain; the last stage is the sample seen by the debouncer
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int k = 0; k < SYNC_STAGE; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int k = 1; k < SYNC_STAGE; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s        = sync_q[SYNC_STAGE-1];
  assign bypass   = ~dben_q | {PIN_NUM{dbthr_q == '0}};
  assign dbthr_m1 = dbthr_q - DB_WIDTH'(1);
  // Bypassed pins see the sample directly so IN latency equals the synchroniser depth
  assign d        = (bypass & s) | (~bypass & db_q);

  // Per-pin debounce: accept a new level after DBTHR consecutive mismatching cycles.
  // The >= compare lets a counter stranded above a freshly lowered threshold still resolve.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      db_q     <= '0;
      d_prev_q <= '0;
      for (int i = 0; i < PIN_NUM; i++) cnt_q[i] <= '0;
    end else begin
      d_prev_q <= d;
      for (int i = 0; i < PIN_NUM; i++) begin
        if (bypass[i] || (s[i] == db_q[i])) begin
          db_q[i]  <= s[i];
          cnt_q[i] <= '0;
        end else if (cnt_q[i] >= dbthr_m1) begin
          db_q[i]  <= s[i];
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + DB_WIDTH'(1);
        end
      end
    end
  end

  assign rise      = d & ~d_prev_q;
  assign fall      = ~d & d_prev_q;
  assign lvl_trig  = ~(d ^ intpol_q);
  assign edge_trig = (intboth_q & (d ^ d_prev_q)) |
                     (~intboth_q & ((intpol_q & rise) | (~intpol_q & fall)));
  assign trig      = (~inttype_q & lvl_trig) | (inttype_q & edge_trig);
  assign set       = inten_q & trig;
  assign w1c       = (wr_en && (off == OFF_INTEN + 4'd4)) ? wdata : '0;
  // A new event on the same edge as its W1C wins, so live level sources keep irq asserted
  assign intstat_nxt = (intstat_q & ~w1c) | set;

  // Next INTEN value, needed so irq_o tracks enable writes on the same edge
  always_comb begin
    inten_nxt = inten_q;
    if (wr_en && (off == OFF_INTEN)) inten_nxt = wdata;
  end

  // Interrupt enable, sticky status and registered interrupt output
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      inten_q   <= '0;
      intstat_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      inten_q   <= inten_nxt;
      intstat_q <= intstat_nxt;
      irq_q     <= |(intstat_nxt & inten_nxt);
    end
  end

  assign irq_o = irq_q;

  // Read mux: only valid read accesses drive data, everything else reads zero
  always_comb begin
    rd_pins = '0;
    case (off)
      OFF_DIR:     rd_pins = dir_q;
      OFF_IN:      rd_pins = d;
      OFF_OUT:     rd_pins = out_q;
      OFF_INTEN:   rd_pins = inten_q;
      OFF_INTTYPE: rd_pins = inttype_q;
      OFF_INTPOL:  rd_pins = intpol_q;
      OFF_INTBOTH: rd_pins = intboth_q;
      OFF_INTSTAT: rd_pins = intstat_q;
      OFF_DBEN:    rd_pins = dben_q;
      default: ;
    endcase
    rdata = '0;
    rdata[PIN_NUM-1:0] = rd_pins;
    if (off == OFF_DBTHR) rdata = 32'(dbthr_q);
    if (!rd_en) rdata = '0;
  end

  assign apb.prdata = rdata;

endmodule

// File: tb/tb_apb4_gpio_v2.sv
// Bench for apb4_gpio_v2: register-map vector table plus hand-written timing,
// debounce, interrupt and reset sequences; APB responses go through a scoreboard queue.
module tb_apb4_gpio_v2;
  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_dir;
  logic        irq;
  int          total = 0;
  int          bad = 0;

  localparam logic [3:0] DIR = 4'd0, IN = 4'd1, OUT = 4'd2, OUTSET = 4'd3, OUTCLR = 4'd4;
  localparam logic [3:0] OUTTGL = 4'd5, INTEN = 4'd6, INTTYPE = 4'd7, INTPOL = 4'd8;
  localparam logic [3:0] INTBOTH = 4'd9, INTSTAT = 4'd10, DBTHR = 4'd11, DBEN = 4'd12;

  apb4_gpio_v2_if bus();

  apb4_gpio_v2 #(.PIN_NUM(32), .SYNC_STAGE(2), .DB_WIDTH(8)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .apb        (bus),
    .gpio_in_i  (gpio_in),
    .gpio_out_o (gpio_out),
    .gpio_dir_o (gpio_dir),
    .irq_o      (irq)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          wr;
    logic [3:0]  off;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer; the expectation is queued at setup and compared in the access phase
  task automatic apb_xfer(input bit wr, input logic [3:0] off, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_err, input string name);
    exp_t e;
    e.rd = exp_rd; e.err = exp_err; e.name = name;
    sb_q.push_back(e);
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = {26'd0, off, 2'b00}; bus.pwdata = wd;
    @(negedge pclk);
    bus.penable = 1'b1;
    #1;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      check({e.name, " pslverr"}, 32'(bus.pslverr), 32'(e.err));
      if (!wr) check({e.name, " prdata"}, bus.prdata, e.rd);
    end
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] wd);
    apb_xfer(1'b1, off, wd, 32'h0, 1'b0, "write");
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string name);
    apb_xfer(1'b0, off, 32'h0, exp, 1'b0, name);
  endtask

  // Park the bus in a continuous read so prdata follows the register every cycle
  task automatic hold_rd(input logic [3:0] off);
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0;
    bus.paddr = {26'd0, off, 2'b00};
  endtask

  task automatic bus_idle();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vt[20];
    bit   seen;

    vt[0]  = '{1'b1, DIR,     32'hA5A5_5A5A, 32'h0,         1'b0};
    vt[1]  = '{1'b0, DIR,     32'h0,         32'hA5A5_5A5A, 1'b0};
    vt[2]  = '{1'b1, INTTYPE, 32'h0000_F0F0, 32'h0,         1'b0};
    vt[3]  = '{1'b0, INTTYPE, 32'h0,         32'h0000_F0F0, 1'b0};
    vt[4]  = '{1'b1, INTPOL,  32'h1234_5678, 32'h0,         1'b0};
    vt[5]  = '{1'b0, INTPOL,  32'h0,         32'h1234_5678, 1'b0};
    vt[6]  = '{1'b1, INTBOTH, 32'h8000_0001, 32'h0,         1'b0};
    vt[7]  = '{1'b0, INTBOTH, 32'h0,         32'h8000_0001, 1'b0};
    vt[8]  = '{1'b1, DBTHR,   32'hFFFF_FF07, 32'h0,         1'b0};
    vt[9]  = '{1'b0, DBTHR,   32'h0,         32'h0000_0007, 1'b0};
    vt[10] = '{1'b0, OUTSET,  32'h0,         32'h0,         1'b0};
    vt[11] = '{1'b0, IN,      32'h0,         32'h0,         1'b0};
    vt[12] = '{1'b1, IN,      32'hFFFF_FFFF, 32'h0,         1'b1};
    vt[13] = '{1'b0, 4'd13,   32'h0,         32'h0,         1'b1};
    vt[14] = '{1'b1, 4'd14,   32'hFFFF_FFFF, 32'h0,         1'b1};
    vt[15] = '{1'b0, 4'd15,   32'h0,         32'h0,         1'b1};
    vt[16] = '{1'b0, DIR,     32'h0,         32'hA5A5_5A5A, 1'b0};
    vt[17] = '{1'b1, DBEN,    32'h0000_FFFF, 32'h0,         1'b0};
    vt[18] = '{1'b0, DBEN,    32'h0,         32'h0000_FFFF, 1'b0};
    vt[19] = '{1'b0, INTSTAT, 32'h0,         32'h0,         1'b0};

    bus_idle();
    bus.paddr = '0; bus.pwdata = '0;
    repeat (3) @(negedge pclk);
    check("reset gpio_out", gpio_out, 32'h0);
    check("reset gpio_dir", gpio_dir, 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset prdata", bus.prdata, 32'h0);
    check("reset pslverr", 32'(bus.pslverr), 32'h0);
    check("pready", 32'(bus.pready), 32'h1);
    presetn = 1'b1;

    // Register map vectors
    for (int i = 0; i < 20; i++)
      apb_xfer(vt[i].wr, vt[i].off, vt[i].wd, vt[i].rd, vt[i].err, $sformatf("vec%0d", i));
    check("gpio_dir after DIR", gpio_dir, 32'hA5A5_5A5A);

    // Output set/clear/toggle aliases
    wr(OUT, 32'h0F);     check("OUT write", gpio_out, 32'h0F);
    wr(OUTSET, 32'hF0);  check("OUTSET", gpio_out, 32'hFF);
    wr(OUTCLR, 32'h03);  check("OUTCLR", gpio_out, 32'hFC);
    wr(OUTTGL, 32'hFF);  check("OUTTGL", gpio_out, 32'h03);
    rd(OUT, 32'h03, "OUT readback");
    rd(OUTTGL, 32'h0, "OUTTGL reads 0");

    // Rising-edge interrupt on pin 0, synchroniser and irq latency
    wr(DBEN, 32'h0); wr(DBTHR, 32'h0); wr(INTBOTH, 32'h0);
    wr(INTTYPE, 32'h1); wr(INTPOL, 32'h1); wr(INTSTAT, 32'hFFFF_FFFF); wr(INTEN, 32'h1);
    rd(INTSTAT, 32'h0, "intstat before edge");
    hold_rd(IN);
    gpio_in[0] = 1'b1;
    @(negedge pclk); #1; check("IN after 1 cycle", bus.prdata, 32'h0);
    @(negedge pclk); #1; check("IN after 2 cycles", bus.prdata, 32'h1);
    check("irq before status", 32'(irq), 32'h0);
    @(negedge pclk); #1; check("irq after edge", 32'(irq), 32'h1);
    bus_idle();
    rd(INTSTAT, 32'h1, "intstat pin0");
    wr(INTSTAT, 32'h1);
    check("irq after W1C", 32'(irq), 32'h0);
    rd(INTSTAT, 32'h0, "intstat pin0 cleared");
    wr(INTEN, 32'h0); gpio_in = '0;
    repeat (4) @(negedge pclk);
    wr(INTSTAT, 32'hFFFF_FFFF);

    // Debounce on pin 3: a 3-cycle glitch is rejected, a steady level passes after 4
    wr(INTTYPE, 32'h8); wr(INTPOL, 32'h8); wr(DBTHR, 32'h4); wr(DBEN, 32'h8);
    wr(INTSTAT, 32'hFFFF_FFFF); wr(INTEN, 32'h8);
    hold_rd(IN);
    gpio_in[3] = 1'b1;
    repeat (3) @(negedge pclk);
    gpio_in[3] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge pclk); #1;
      if (bus.prdata[3] || irq) seen = 1'b1;
    end
    check("glitch rejected", 32'(seen), 32'h0);
    bus_idle();
    rd(INTSTAT, 32'h0, "intstat after glitch");
    hold_rd(IN);
    gpio_in[3] = 1'b1;
    repeat (5) @(negedge pclk); #1;
    check("IN3 at 5 cycles", bus.prdata, 32'h0);
    @(negedge pclk); #1;
    check("IN3 at 6 cycles", bus.prdata, 32'h8);
    @(negedge pclk); #1;
    check("irq debounced edge", 32'(irq), 32'h1);
    bus_idle();
    wr(INTEN, 32'h0); gpio_in = '0;
    repeat (10) @(negedge pclk);
    wr(INTSTAT, 32'hFFFF_FFFF); wr(DBEN, 32'h0);

    // Level-low interrupt on pin 5: W1C cannot clear an active level source
    wr(INTTYPE, 32'h0); wr(INTPOL, 32'h0); wr(INTBOTH, 32'h0);
    wr(INTSTAT, 32'hFFFF_FFFF); wr(INTEN, 32'h20);
    rd(INTSTAT, 32'h20, "level low set");
    wr(INTSTAT, 32'h20);
    rd(INTSTAT, 32'h20, "level W1C resets");
    check("irq level held", 32'(irq), 32'h1);
    wr(INTEN, 32'h0);
    check("irq after INTEN off", 32'(irq), 32'h0);
    rd(INTSTAT, 32'h20, "INTEN off keeps stat");
    gpio_in[5] = 1'b1;
    repeat (4) @(negedge pclk);
    wr(INTSTAT, 32'h20);
    rd(INTSTAT, 32'h0, "level cleared");

    // Both-edge interrupt on pin 7
    wr(INTTYPE, 32'h80); wr(INTBOTH, 32'h80); wr(INTPOL, 32'h0);
    wr(INTSTAT, 32'hFFFF_FFFF); wr(INTEN, 32'h80);
    rd(INTSTAT, 32'h0, "both idle");
    gpio_in[7] = 1'b1;
    repeat (4) @(negedge pclk);
    rd(INTSTAT, 32'h80, "both rise");
    check("irq both rise", 32'(irq), 32'h1);
    wr(INTSTAT, 32'h80);
    rd(INTSTAT, 32'h0, "both cleared");
    gpio_in[7] = 1'b0;
    repeat (4) @(negedge pclk);
    rd(INTSTAT, 32'h80, "both fall");
    wr(INTSTAT, 32'h80);

    // Error access at offset 14 leaves state untouched
    apb_xfer(1'b1, 4'd14, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr off14");
    apb_xfer(1'b0, 4'd14, 32'h0, 32'h0, 1'b1, "rd off14");
    check("OUT after err", gpio_out, 32'h03);
    check("DIR after err", gpio_dir, 32'hA5A5_5A5A);
    rd(INTEN, 32'h80, "INTEN after err");
    wr(INTEN, 32'h0);

    // Reset in the middle of a debounce
    wr(DBTHR, 32'h8); wr(DBEN, 32'hFFFF_FFFF); wr(OUT, 32'hFF);
    wr(INTTYPE, 32'h0); wr(INTPOL, 32'h0); wr(INTEN, 32'h1);
    hold_rd(OUT);
    gpio_in[3] = 1'b1;
    repeat (4) @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    check("rst gpio_out", gpio_out, 32'h0);
    check("rst gpio_dir", gpio_dir, 32'h0);
    check("rst irq", 32'(irq), 32'h0);
    check("rst prdata", bus.prdata, 32'h0);
    check("rst pslverr", 32'(bus.pslverr), 32'h0);
    gpio_in = '0;
    bus_idle();
    @(negedge pclk);
    presetn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge pclk); #1;
      if (irq) seen = 1'b1;
    end
    check("irq quiet after reset", 32'(seen), 32'h0);
    rd(IN, 32'h0, "IN after reset");
    rd(INTSTAT, 32'h0, "intstat after reset");
    rd(DBTHR, 32'h0, "DBTHR after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb4_gpio_v2.md
APB4_GPIO_V2 -- requirements
Module: apb4_gpio_v2

Interface
REQ-001 The block SHALL use one clock, pclk; reset is asynchronous and active-low, presetn.
REQ-002 Parameter PIN_NUM, default 32 (range 1..32): number of GPIO pins.
REQ-003 Parameter SYNC_STAGE, default 2 (minimum 2): input synchroniser flop stages.
REQ-004 Parameter DB_WIDTH, default 8 (range 1..16): debounce counter/threshold width.
REQ-005 Ports SHALL be as follows:
pclk  in  1  clock
presetn  in  1  async active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  32  APB address; only [5:2] decoded
pwdata  in  32  write data
prdata  out  32  read data
pready  out  1  tied 1
pslverr  out  1  error response
gpio_in_i  in  PIN_NUM  asynchronous pad inputs
gpio_out_o  out  PIN_NUM  pad output values
gpio_dir_o  out  PIN_NUM  pad direction, 1 = output
irq_o  out  1  interrupt request

Function
REQ-006 Write access SHALL be psel&penable&pwrite; read access SHALL be psel&penable&~pwrite; zero wait states.
REQ-007 Register map (paddr[5:2], bits above PIN_NUM-1 read 0): 0 DIR rw; 1 IN ro; 2 OUT rw; 3 OUTSET wo; 4 OUTCLR wo; 5 OUTTGL wo; 6 INTEN rw; 7 INTTYPE rw (0 level, 1 edge); 8 INTPOL rw; 9 INTBOTH rw; 10 INTSTAT rw1c; 11 DBTHR rw, bits [DB_WIDTH-1:0]; 12 DBEN rw.
REQ-008 OUTSET/OUTCLR/OUTTGL writes SHALL update OUT to OUT|wdata, OUT&~wdata and OUT^wdata respectively, effective at the access edge; these registers read 0.
REQ-009 pslverr SHALL be 1 during the access phase for offsets 13..15 and for writes to IN; such accesses change no state, and reads of them return 0.
REQ-010 gpio_out_o SHALL equal OUT and gpio_dir_o SHALL equal DIR, directly from flops.
REQ-011 Each pin SHALL pass through SYNC_STAGE flops to give sample s[i].
REQ-012 When DBEN[i]=0 or DBTHR=0, the debounced value d[i] SHALL take s[i] each cycle.
REQ-013 Otherwise, per-pin counter cnt[i] SHALL clear when s[i]==d[i], increment when they differ, and d[i] SHALL load s[i] and cnt[i] clear on the cycle cnt[i]==DBTHR-1 with mismatch, so d changes after DBTHR consecutive mismatching cycles.
REQ-014 Counters SHALL saturate and never wrap.
REQ-015 A DBTHR write SHALL take effect on the next cycle without clearing counters.
REQ-016 IN SHALL read d.
REQ-017 Edge detection SHALL use d versus d_prev (d delayed one cycle).
REQ-018 Per-pin trigger: level (INTTYPE=0) = d==INTPOL; edge with INTBOTH=1 = d!=d_prev; edge with INTBOTH=0 = rise if INTPOL=1, fall if INTPOL=0.
REQ-019 INTSTAT[i] SHALL set at the clock edge where INTEN[i]&trigger[i] is true; it is sticky.
REQ-020 INTSTAT SHALL clear only by writing 1 to the bit; if set and clear coincide, set SHALL win.
REQ-021 Clearing INTEN SHALL not clear INTSTAT.
REQ-022 irq_o SHALL equal |(INTSTAT&INTEN), from flops.
REQ-023 A level source still active after a W1C SHALL re-set its bit on that same edge, so irq_o stays 1.
REQ-024 Latency without debounce: pad change to IN = SYNC_STAGE cycles; IN change to INTSTAT/irq_o = 1 cycle.

Reset
REQ-025 On presetn low, all registers, sync flops, d, d_prev and counters SHALL clear to 0 immediately.
REQ-026 Reset values: gpio_out_o=0, gpio_dir_o=0 (all inputs), irq_o=0, pslverr=0, prdata=0.
REQ-027 A bounce in progress during reset SHALL be discarded, and no interrupt SHALL be generated on the first cycles after reset release for pins held low.

Verification
REQ-028 OUT=0x0F; OUTSET 0xF0 -> 0xFF; OUTCLR 0x03 -> 0xFC; OUTTGL 0xFF -> 0x03 on gpio_out_o.
REQ-029 PIN_NUM=32, SYNC_STAGE=2, pin0 rising edge, INTEN=1, INTTYPE=1, INTPOL=1 -> IN[0]=1 after 2 cycles, INTSTAT=0x1 and irq_o=1 one cycle later; W1C 0x1 -> irq_o=0.
REQ-030 DBEN[3]=1, DBTHR=4; pin3 glitches high for 3 cycles -> IN[3] stays 0, no interrupt; held high 4+ cycles -> IN[3]=1.
REQ-031 Level-low interrupt on pin5 (INTTYPE=0, INTPOL=0, input held 0) with W1C -> INTSTAT[5] stays 1; drive 1, then W1C -> INTSTAT[5]=0.
REQ-032 INTBOTH=1 on pin7 toggled twice -> INTSTAT[7] sets on each edge; write at offset 14 -> pslverr=1, prdata=0, no state change.
REQ-033 Assert presetn mid-debounce -> all outputs 0; after release, pin held 0 -> irq_o stays 0.
